// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control path.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus the R-type funct field to an ALU control code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl_sig
);

  always_comb begin
    alu_ctrl_sig = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_ctrl_sig = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alu_ctrl_sig = ALU_SUB;
          FN_AND:  alu_ctrl_sig = ALU_AND;
          FN_OR:   alu_ctrl_sig = ALU_OR;
          FN_SLT:  alu_ctrl_sig = ALU_SLT;
          default: alu_ctrl_sig = ALU_ADD;
        endcase
      end
      default: alu_ctrl_sig = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute over one shared memory port.
// Memory handshake: a transfer completes in a cycle with mem_req=1 and mem_ready=1; otherwise state and outputs hold.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl_sig,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       inst_done,
  output logic       illegal_op,
  output state_t     state_o
);

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       alu_use;
  logic [2:0] dec_ctrl;

  alu_decoder u_alu_decoder (
    .aluop        (aluop),
    .funct        (funct),
    .alu_ctrl_sig (dec_ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    pc_src     = PC_ALU;
    pc_en      = 1'b0;
    inst_done  = 1'b0;
    illegal_op = 1'b0;
    aluop      = ALUOP_ADD;
    alu_use    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_use   = 1'b1;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMMSH;
        alu_use   = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_use   = 1'b1;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        inst_done  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        inst_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        alu_use   = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        inst_done = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        alu_use   = 1'b1;
        pc_src    = PC_ALUOUT;
        pc_en     = zero;
        inst_done = 1'b1;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_use   = 1'b1;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        inst_done = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_src    = PC_JUMP;
        pc_en     = 1'b1;
        inst_done = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // The ALU code is only meaningful in states that use the ALU; elsewhere it idles at 0.
  assign alu_ctrl_sig = alu_use ? dec_ctrl : 3'b000;
  assign state_o      = state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM that sequences the 32-bit MIPS-subset datapath over multiple cycles per instruction, sharing one memory port between instruction fetch and data access. It decodes the opcode/funct of the latched instruction, drives every datapath select and write enable, and stalls on a ready handshake from the unified memory. It sits beside the datapath in the mother board, replacing the single-cycle combinational decoder.

## Interface
Parameters:
- none; widths are fixed by the ISA.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- iord  out  1  0: address = PC, 1: address = ALU result register.
- mem_write  out  1  access is a write.
- ir_write  out  1  load instruction register.
- reg_dst  out  1  1: rd, 0: rt.
- mem_to_reg  out  1  1: write-back from data register.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0: PC, 1: rs.
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_ctrl_sig  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  out  2  00 ALU out, 01 ALU result register, 10 jump target.
- pc_en  out  1  PC write enable.
- inst_done  out  1  one-cycle pulse in an instruction's final state.
- illegal_op  out  1  one-cycle pulse in DECODE on an unknown opcode.

## Operation
- Moore FSM; outputs are combinational from state, plus mem_ready/zero where noted. Unlisted outputs are 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. ir_write=pc_en=mem_ready. Go to DECODE on mem_ready, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target). Next state: lw/sw→MEMADR, R→EXECUTE, beq→BRANCH, addi→ADDIEX, j→JUMP, other→FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next: lw→MEMRD, sw→MEMWR.
- MEMRD: mem_req=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, inst_done=1 → FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1. inst_done=mem_ready. Go to FETCH on mem_ready.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl_sig from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other → 010 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1, inst_done=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero, inst_done=1 → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, inst_done=1 → FETCH.
- JUMP: pc_src=10, pc_en=1, inst_done=1 → FETCH.

## Timing
- Reset: state=FETCH immediately (asynchronous). Outputs then take FETCH values: mem_req=1, alu_src_b=01, alu_ctrl_sig=010, ir_write=pc_en=mem_ready, all others 0. Write strobes drop immediately when reset asserts mid-instruction, and no partial write-back occurs.
- Zero-wait latency (mem_ready tied 1), in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each wait cycle (mem_ready=0 while mem_req=1) adds one cycle. The FSM holds state and all outputs stable, including iord and mem_write.
- A memory transfer completes only in a cycle where mem_req and mem_ready are both 1. mem_ready while mem_req=0 is ignored.
- pc_en and ir_write in FETCH assert only in the completing cycle, so PC+4 is written exactly once per instruction.
- beq: pc_en is combinational from zero in BRANCH; the PC updates on the edge that leaves BRANCH.

## Structure
- mc_pkg: state_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP); opcode and funct constants; alu_ctrl_sig codes; alu_src_b and pc_src encodings.
- Sub-module alu_decoder: combinational; aluop(2) and funct(6) in, alu_ctrl_sig(3) out. aluop 00 = add, 01 = sub, 10 = funct table. Instantiated once.
- State register plus next-state logic and output logic in multicycle_ctrl.

## Test plan
- Reset with mem_ready=1 held: state FETCH; ir_write=1, pc_en=1, alu_src_b=01, alu_ctrl_sig=010 in the first cycle.
- lw (opcode 100011), mem_ready=1: states FETCH→DECODE→MEMADR→MEMRD→MEMWB; reg_write=1 with mem_to_reg=1 in cycle 5 only; inst_done pulse in cycle 5.
- sw, with mem_ready=0 for 3 cycles in MEMWR: mem_write/iord/mem_req stay 1 for 4 cycles; inst_done only in the mem_ready cycle; 7 cycles total.
- beq in two runs, zero=1 then zero=0: pc_en=1, pc_src=01 in BRANCH for the first; pc_en=0 for the second; both take 3 cycles.
- R-type, each funct value in turn: EXECUTE alu_ctrl_sig is 010/110/000/001/111 for add/sub/and/or/slt, and 010 for funct 000000. ALUWB has reg_dst=1.
- Opcode 111111: illegal_op pulse in DECODE, back in FETCH next cycle, no reg_write. Then reset asserted mid-MEMWR: mem_write falls in the same cycle and state is FETCH.
